// File: rtl/instruction_fetch_queue_if.sv
// Bus bundle for instruction_fetch_queue: instruction-memory port, decode
// handshake, branch redirect inputs and queue occupancy.
//
// Handshake: the fetch queue presents an entry with valid_out=1; decode takes
// it by holding ready_in=1 in the same cycle, and the transfer happens at the
// rising edge where both are high. The data fields stay stable while
// valid_out=1 and ready_in=0.
//
// master = the fetch queue, slave = the surrounding pipeline / memory.
interface instruction_fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  logic [ADDR_W-1:0]          imem_addr;
  logic [INSTR_W-1:0]         imem_data;
  logic                       redirect;
  logic                       Branchreg;
  logic [ADDR_W-1:0]          add_pc;
  logic [ADDR_W-1:0]          read_data_1;
  logic                       valid_out;
  logic                       ready_in;
  logic [INSTR_W-1:0]         instruction_out;
  logic [ADDR_W-1:0]          PC_out;
  logic [ADDR_W-1:0]          PC_branch_link_out;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output imem_addr, valid_out, instruction_out, PC_out, PC_branch_link_out, count,
    input  imem_data, redirect, Branchreg, add_pc, read_data_1, ready_in
  );

  modport slave (
    input  imem_addr, valid_out, instruction_out, PC_out, PC_branch_link_out, count,
    output imem_data, redirect, Branchreg, add_pc, read_data_1, ready_in
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: runs fetch ahead of decode by sequential PC+4 into
// a DEPTH-entry circular buffer of {PC, instruction, PC+4} triples. A branch
// redirect flushes the buffer and restarts fetch at the resolved target.
//
// Optional feature macro: FETCH_BYPASS_EN. When defined, an empty queue with
// decode ready passes the current memory word straight to the outputs in the
// same cycle instead of buffering it first.
module instruction_fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic reset,
  instruction_fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  link_mem  [DEPTH];

  logic [ADDR_W-1:0]  fetch_pc_plus4;
  logic [ADDR_W-1:0]  target;
  logic               head_valid;
  logic               full;
  logic               bypass;
  logic               deq;
  logic               enq;

  assign fetch_pc_plus4 = fetch_pc + ADDR_W'(4);
  assign target         = bus.Branchreg ? bus.read_data_1 : bus.add_pc;
  assign head_valid     = (count_q != '0);
  assign full           = (count_q == CNT_W'(DEPTH));

`ifdef FETCH_BYPASS_EN
  // Empty queue and decode waiting: hand the memory word over directly.
  assign bypass = !head_valid && !bus.redirect && bus.ready_in;
`else
  assign bypass = 1'b0;
`endif

  // A queued head is consumed whenever decode is ready, even in a redirect cycle.
  assign deq = head_valid && bus.ready_in;
  // Room exists if not full, or if the head leaves in the same cycle.
  assign enq = !bus.redirect && !bypass && (!full || deq);

  assign bus.imem_addr = fetch_pc;
  assign bus.count     = count_q;

  // Head presentation: queued entry, bypassed fetch word, or all zeros when idle.
  always_comb begin
    bus.valid_out          = 1'b0;
    bus.instruction_out    = '0;
    bus.PC_out             = '0;
    bus.PC_branch_link_out = '0;
    if (head_valid) begin
      bus.valid_out          = 1'b1;
      bus.instruction_out    = instr_mem[rd_ptr];
      bus.PC_out             = pc_mem[rd_ptr];
      bus.PC_branch_link_out = link_mem[rd_ptr];
    end else if (bypass) begin
      bus.valid_out          = 1'b1;
      bus.instruction_out    = bus.imem_data;
      bus.PC_out             = fetch_pc;
      bus.PC_branch_link_out = fetch_pc_plus4;
    end
  end

  // Control state: fetch PC, pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (enq || bypass) begin
        fetch_pc <= fetch_pc_plus4;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_data;
      link_mem[wr_ptr]  <= fetch_pc_plus4;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue (default build, DEPTH=4, RESET_PC=0).
// A cycle table checks occupancy, fetch address and head PC; a scoreboard of
// expected head PCs checks every accepted handshake for PC, link and word.
module tb_instruction_fetch_queue;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int DP = 4;
  localparam int NV = 22;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [AW-1:0] exp_q[$];

  instruction_fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) bus ();

  instruction_fetch_queue #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .RESET_PC(64'h0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: distinct word per address so PC and data cannot be confused.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0], a[15:0] ^ 16'hFFFF};
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          redir;
    logic          breg;
    logic          rdy;
    logic [AW-1:0] add;
    logic [AW-1:0] rd1;
    logic          e_valid;
    logic [2:0]    e_count;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic redir, input logic breg,
                              input logic rdy, input logic [AW-1:0] add,
                              input logic [AW-1:0] rd1, input logic e_valid,
                              input logic [2:0] e_count, input logic [AW-1:0] e_pc,
                              input logic [AW-1:0] e_addr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.breg = breg; v.rdy = rdy;
    v.add = add; v.rd1 = rd1; v.e_valid = e_valid; v.e_count = e_count;
    v.e_pc = e_pc; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_stream(input logic [AW-1:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + AW'(4 * i));
  endtask

  // Scoreboard: compare a head accepted at the coming edge, then restart the
  // expected stream if this edge resets or redirects.
  task automatic sb();
    logic [AW-1:0] e;
    if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got head %h want no handshake", bus.PC_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.PC_out, e);
        chk("sb_link", bus.PC_branch_link_out, e + 64'd4);
        chk("sb_instr", AW'(bus.instruction_out), AW'(mem_word(e)));
      end
    end
    if (reset) start_stream(64'h0);
    else if (bus.redirect) start_stream(bus.Branchreg ? bus.read_data_1 : bus.add_pc);
  endtask

  // Driver: set inputs mid-cycle, let outputs settle, run the scoreboard.
  task automatic apply(input logic rst, input logic redir, input logic breg,
                       input logic rdy, input logic [AW-1:0] add, input logic [AW-1:0] rd1);
    @(negedge clock);
    reset           = rst;
    bus.redirect    = redir;
    bus.Branchreg   = breg;
    bus.ready_in    = rdy;
    bus.add_pc      = add;
    bus.read_data_1 = rd1;
    #1;
    sb();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.redirect = 1'b0; bus.Branchreg = 1'b0; bus.ready_in = 1'b0;
    bus.add_pc = '0; bus.read_data_1 = '0;

    //            rst redir breg rdy add        rd1        v  cnt pc          addr
    vecs[0]  = mk(1, 0, 0, 1, 64'h0,     64'h0,     0, 0, 64'h0,     64'h0);
    vecs[1]  = mk(0, 0, 0, 1, 64'h0,     64'h0,     0, 0, 64'h0,     64'h0);
    vecs[2]  = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 1, 64'h0,     64'h4);
    vecs[3]  = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 1, 64'h4,     64'h8);
    vecs[4]  = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 1, 64'h8,     64'hC);
    vecs[5]  = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 2, 64'h8,     64'h10);
    vecs[6]  = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 3, 64'h8,     64'h14);
    vecs[7]  = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 4, 64'h8,     64'h18);
    vecs[8]  = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 4, 64'h8,     64'h18);
    vecs[9]  = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 4, 64'h8,     64'h18);
    vecs[10] = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 4, 64'hC,     64'h1C);
    vecs[11] = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 4, 64'h10,    64'h20);
    vecs[12] = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 4, 64'h14,    64'h24);
    vecs[13] = mk(0, 1, 0, 0, 64'h100,   64'h0,     1, 4, 64'h14,    64'h24);
    vecs[14] = mk(0, 0, 0, 0, 64'h0,     64'h0,     0, 0, 64'h0,     64'h100);
    vecs[15] = mk(0, 0, 0, 1, 64'h0,     64'h0,     1, 1, 64'h100,   64'h104);
    vecs[16] = mk(0, 1, 1, 1, 64'h100,   64'h2000,  1, 1, 64'h104,   64'h108);
    vecs[17] = mk(0, 0, 0, 1, 64'h0,     64'h0,     0, 0, 64'h0,     64'h2000);
    vecs[18] = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 1, 64'h2000,  64'h2004);
    vecs[19] = mk(1, 1, 0, 1, 64'h300,   64'h0,     1, 2, 64'h2000,  64'h2008);
    vecs[20] = mk(0, 0, 0, 0, 64'h0,     64'h0,     0, 0, 64'h0,     64'h0);
    vecs[21] = mk(0, 0, 0, 0, 64'h0,     64'h0,     1, 1, 64'h0,     64'h4);

    // Initial reset
    repeat (2) @(posedge clock);

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst, vecs[i].redir, vecs[i].breg, vecs[i].rdy, vecs[i].add, vecs[i].rd1);
      chk($sformatf("valid[%0d]", i), AW'(bus.valid_out), AW'(vecs[i].e_valid));
      chk($sformatf("count[%0d]", i), AW'(bus.count), AW'(vecs[i].e_count));
      chk($sformatf("pc[%0d]", i), bus.PC_out, vecs[i].e_pc);
      chk($sformatf("addr[%0d]", i), bus.imem_addr, vecs[i].e_addr);
      if (!vecs[i].e_valid) begin
        chk($sformatf("instr_idle[%0d]", i), AW'(bus.instruction_out), 64'h0);
        chk($sformatf("link_idle[%0d]", i), bus.PC_branch_link_out, 64'h0);
      end
    end

    // PC wrap at the top of the address space
    apply(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    apply(0, 0, 0, 1, 64'h0, 64'h0);
    chk("wrap_empty", AW'(bus.count), 64'h0);
    chk("wrap_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 64'h0, 64'h0);

    // Fill, then 12 cycles of simultaneous enqueue/dequeue on a full queue
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 64'h0, 64'h0);
    chk("fill_count", AW'(bus.count), 64'h4);
    for (int i = 0; i < 12; i++) begin
      apply(0, 0, 0, 1, 64'h0, 64'h0);
      chk($sformatf("full_count[%0d]", i), AW'(bus.count), 64'h4);
      chk($sformatf("full_valid[%0d]", i), AW'(bus.valid_out), 64'h1);
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
